// File: rtl/mips_multicycle_ctrl_if.sv
// Control bundle between the multi-cycle MIPS controller and its datapath.
interface mips_multicycle_ctrl_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_control;
    logic [1:0] pc_src;
    logic       pc_en;
    logic       illegal;
    logic [3:0] state;

    // Controller side
    modport master (
        input  op, funct, zero, mem_ready,
        output iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
               alu_src_a, alu_src_b, alu_control, pc_src, pc_en, illegal, state
    );

    // Datapath side
    modport slave (
        output op, funct, zero, mem_ready,
        input  iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
               alu_src_a, alu_src_b, alu_control, pc_src, pc_en, illegal, state
    );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: sequences the shared ALU, datapath enables and
// memory handshake; decodes op/funct into the 4-bit ALU control code.
module mips_multicycle_ctrl #(
    parameter bit MEM_HANDSHAKE = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    mips_multicycle_ctrl_if.master ctrl_if
);
    localparam int unsigned STATE_W = 4;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_e;

    state_e state_q;
    state_e state_d;
    logic   mem_rdy_c;
    logic   pc_write_c;
    logic   branch_c;

    // With the handshake disabled every memory access completes in one cycle
    assign mem_rdy_c     = MEM_HANDSHAKE ? ctrl_if.mem_ready : 1'b1;
    assign ctrl_if.state = state_q;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and output decode; everything stays at its idle value while in reset
    always_comb begin
        state_d             = state_q;
        pc_write_c          = 1'b0;
        branch_c            = 1'b0;
        ctrl_if.iord        = 1'b0;
        ctrl_if.mem_write   = 1'b0;
        ctrl_if.ir_write    = 1'b0;
        ctrl_if.reg_dst     = 1'b0;
        ctrl_if.mem_to_reg  = 1'b0;
        ctrl_if.reg_write   = 1'b0;
        ctrl_if.alu_src_a   = 1'b0;
        ctrl_if.alu_src_b   = 2'b00;
        ctrl_if.alu_control = ALU_ADD;
        ctrl_if.pc_src      = 2'b00;
        ctrl_if.illegal     = 1'b0;
        if (rst_n) begin
            case (state_q)
                S_FETCH: begin
                    ctrl_if.alu_src_b = 2'b01;
                    if (mem_rdy_c) begin
                        ctrl_if.ir_write = 1'b1;
                        pc_write_c       = 1'b1;
                        state_d          = S_DECODE;
                    end
                end
                S_DECODE: begin
                    ctrl_if.alu_src_b = 2'b11;
                    case (ctrl_if.op)
                        OP_LW, OP_SW: state_d = S_MEMADR;
                        OP_RTYPE:     state_d = S_EXEC;
                        OP_BEQ:       state_d = S_BRANCH;
                        OP_ADDI:      state_d = S_ADDIEX;
                        OP_J:         state_d = S_JUMP;
                        default: begin
                            ctrl_if.illegal = 1'b1;
                            state_d         = S_FETCH;
                        end
                    endcase
                end
                S_MEMADR: begin
                    ctrl_if.alu_src_a = 1'b1;
                    ctrl_if.alu_src_b = 2'b10;
                    state_d = (ctrl_if.op == OP_SW) ? S_MEMWR : S_MEMRD;
                end
                S_MEMRD: begin
                    ctrl_if.iord = 1'b1;
                    if (mem_rdy_c) state_d = S_MEMWB;
                end
                S_MEMWB: begin
                    ctrl_if.mem_to_reg = 1'b1;
                    ctrl_if.reg_write  = 1'b1;
                    state_d            = S_FETCH;
                end
                S_MEMWR: begin
                    ctrl_if.iord      = 1'b1;
                    ctrl_if.mem_write = 1'b1;
                    if (mem_rdy_c) state_d = S_FETCH;
                end
                S_EXEC: begin
                    ctrl_if.alu_src_a = 1'b1;
                    state_d           = S_ALUWB;
                    case (ctrl_if.funct)
                        6'b100000: ctrl_if.alu_control = ALU_ADD;
                        6'b100010: ctrl_if.alu_control = ALU_SUB;
                        6'b100100: ctrl_if.alu_control = ALU_AND;
                        6'b100101: ctrl_if.alu_control = ALU_OR;
                        6'b101010: ctrl_if.alu_control = ALU_SLT;
                        6'b100111: ctrl_if.alu_control = ALU_NOR;
                        default: begin
                            ctrl_if.illegal = 1'b1;
                            state_d         = S_FETCH;
                        end
                    endcase
                end
                S_ALUWB: begin
                    ctrl_if.reg_dst   = 1'b1;
                    ctrl_if.reg_write = 1'b1;
                    state_d           = S_FETCH;
                end
                S_BRANCH: begin
                    ctrl_if.alu_src_a   = 1'b1;
                    ctrl_if.alu_control = ALU_SUB;
                    ctrl_if.pc_src      = 2'b01;
                    branch_c            = 1'b1;
                    state_d             = S_FETCH;
                end
                S_ADDIEX: begin
                    ctrl_if.alu_src_a = 1'b1;
                    ctrl_if.alu_src_b = 2'b10;
                    state_d           = S_ADDIWB;
                end
                S_ADDIWB: begin
                    ctrl_if.reg_write = 1'b1;
                    state_d           = S_FETCH;
                end
                S_JUMP: begin
                    ctrl_if.pc_src = 2'b10;
                    pc_write_c     = 1'b1;
                    state_d        = S_FETCH;
                end
                default: state_d = S_FETCH;
            endcase
        end
        ctrl_if.pc_en = pc_write_c | (branch_c & ctrl_if.zero);
    end
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Randomized scoreboard bench for the multi-cycle MIPS control FSM.
module tb_mips_multicycle_ctrl;
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    typedef struct packed {
        logic [3:0] state;
        logic       iord;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [3:0] alu_control;
        logic [1:0] pc_src;
        logic       pc_en;
        logic       illegal;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic rst1_n;
    always #5 clk = ~clk;

    mips_multicycle_ctrl_if bus0();
    mips_multicycle_ctrl_if bus1();

    mips_multicycle_ctrl #(.MEM_HANDSHAKE(1'b1)) dut0 (
        .clk(clk), .rst_n(rst_n), .ctrl_if(bus0)
    );
    mips_multicycle_ctrl #(.MEM_HANDSHAKE(1'b0)) dut1 (
        .clk(clk), .rst_n(rst1_n), .ctrl_if(bus1)
    );

    exp_t sb_q[$];
    exp_t mon_e;
    exp_t mon_a;
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic op_known(logic [5:0] op);
        return (op == OP_LW) || (op == OP_SW) || (op == OP_R) ||
               (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
    endfunction

    function automatic logic [4:0] funct_info(logic [5:0] fn);
        // {valid, alu code}
        case (fn)
            6'b100000: return {1'b1, 4'b0010};
            6'b100010: return {1'b1, 4'b0110};
            6'b100100: return {1'b1, 4'b0000};
            6'b100101: return {1'b1, 4'b0001};
            6'b101010: return {1'b1, 4'b0111};
            6'b100111: return {1'b1, 4'b1100};
            default:   return {1'b0, 4'b0010};
        endcase
    endfunction

    // Expected control word for one cycle in a given step of an instruction
    function automatic exp_t model(int st, logic [5:0] op, logic [5:0] fn,
                                   logic z, logic rdy, logic in_rst);
        exp_t       e;
        logic [4:0] fi;
        e = '0;
        e.alu_control = 4'b0010;
        if (in_rst) return e;
        e.state = 4'(st);
        fi = funct_info(fn);
        case (st)
            0:  begin e.alu_src_b = 2'b01; e.ir_write = rdy; e.pc_en = rdy; end
            1:  begin e.alu_src_b = 2'b11; e.illegal = !op_known(op); end
            2:  begin e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; end
            3:  e.iord = 1'b1;
            4:  begin e.mem_to_reg = 1'b1; e.reg_write = 1'b1; end
            5:  begin e.iord = 1'b1; e.mem_write = 1'b1; end
            6:  begin e.alu_src_a = 1'b1; e.alu_control = fi[3:0]; e.illegal = !fi[4]; end
            7:  begin e.reg_dst = 1'b1; e.reg_write = 1'b1; end
            8:  begin e.alu_src_a = 1'b1; e.alu_control = 4'b0110; e.pc_src = 2'b01; e.pc_en = z; end
            9:  begin e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; end
            10: e.reg_write = 1'b1;
            11: begin e.pc_src = 2'b10; e.pc_en = 1'b1; end
            default: ;
        endcase
        return e;
    endfunction

    // One clock of stimulus: drive inputs, record expectation, advance
    task automatic step(int st, logic [5:0] op, logic [5:0] fn, logic rdy, logic z);
        bus0.mem_ready = rdy;
        bus0.zero      = z;
        sb_q.push_back(model(st, op, fn, z, rdy, 1'b0));
        @(posedge clk);
        #1;
    endtask

    // Walk one instruction through its expected sequence of steps
    task automatic run_instr(logic [5:0] op, logic [5:0] fn, logic z, int fw, int mw);
        bus0.op    = op;
        bus0.funct = fn;
        repeat (fw) step(0, op, fn, 1'b0, rbit());
        step(0, op, fn, 1'b1, rbit());
        step(1, op, fn, rbit(), rbit());
        case (op)
            OP_LW: begin
                step(2, op, fn, rbit(), rbit());
                repeat (mw) step(3, op, fn, 1'b0, rbit());
                step(3, op, fn, 1'b1, rbit());
                step(4, op, fn, rbit(), rbit());
            end
            OP_SW: begin
                step(2, op, fn, rbit(), rbit());
                repeat (mw) step(5, op, fn, 1'b0, rbit());
                step(5, op, fn, 1'b1, rbit());
            end
            OP_R: begin
                step(6, op, fn, rbit(), rbit());
                if (funct_info(fn) >= 5'b10000) step(7, op, fn, rbit(), rbit());
            end
            OP_BEQ:  step(8, op, fn, rbit(), z);
            OP_ADDI: begin
                step(9, op, fn, rbit(), rbit());
                step(10, op, fn, rbit(), rbit());
            end
            OP_J:    step(11, op, fn, rbit(), rbit());
            default: ;
        endcase
    endtask

    function automatic exp_t sample0();
        exp_t a;
        a.state       = bus0.state;
        a.iord        = bus0.iord;
        a.mem_write   = bus0.mem_write;
        a.ir_write    = bus0.ir_write;
        a.reg_dst     = bus0.reg_dst;
        a.mem_to_reg  = bus0.mem_to_reg;
        a.reg_write   = bus0.reg_write;
        a.alu_src_a   = bus0.alu_src_a;
        a.alu_src_b   = bus0.alu_src_b;
        a.alu_control = bus0.alu_control;
        a.pc_src      = bus0.pc_src;
        a.pc_en       = bus0.pc_en;
        a.illegal     = bus0.illegal;
        return a;
    endfunction

    // Monitor: one control word per cycle, checked mid-cycle
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            mon_a = sample0();
            n_cmp++;
            if (mon_a !== mon_e) begin
                n_bad++;
                $display("FAIL ctrl_word t=%0t got st=%0d word=%b required st=%0d word=%b",
                         $time, mon_a.state, mon_a, mon_e.state, mon_e);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] rop;
        logic [5:0] rfn;
        int         sel;
        int         exp_st [6];
        int         wr_cnt;
        exp_t       r0;
        rst_n  = 1'b0;
        rst1_n = 1'b0;
        bus0.op = '0; bus0.funct = '0; bus0.zero = 1'b0; bus0.mem_ready = 1'b1;
        bus1.op = OP_SW; bus1.funct = '0; bus1.zero = 1'b0; bus1.mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        // Reset state: enables forced low even though mem_ready is high
        r0 = model(0, '0, '0, 1'b0, 1'b1, 1'b1);
        n_cmp++;
        if (sample0() !== r0) begin
            n_bad++;
            $display("FAIL reset_idle got=%b required=%b", sample0(), r0);
        end
        rst_n = 1'b1;

        // Directed instructions
        run_instr(OP_R, 6'b100010, 1'b0, 0, 0);
        run_instr(OP_LW, 6'b000000, 1'b0, 0, 2);
        run_instr(OP_BEQ, 6'b000000, 1'b1, 0, 0);
        run_instr(OP_BEQ, 6'b000000, 1'b0, 0, 0);
        run_instr(6'b111111, 6'b000000, 1'b0, 0, 0);
        run_instr(OP_R, 6'b000000, 1'b0, 0, 0);
        run_instr(OP_SW, 6'b000000, 1'b0, 1, 1);
        run_instr(OP_ADDI, 6'b000000, 1'b0, 0, 0);
        run_instr(OP_J, 6'b000000, 1'b0, 0, 0);

        // Reset asserted in the middle of EXEC
        bus0.op = OP_R; bus0.funct = 6'b100000;
        step(0, OP_R, 6'b100000, 1'b1, 1'b0);
        step(1, OP_R, 6'b100000, 1'b1, 1'b0);
        bus0.mem_ready = 1'b1;
        sb_q.push_back(model(6, OP_R, 6'b100000, 1'b0, 1'b1, 1'b0));
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (bus0.state !== 4'd0 || bus0.reg_write !== 1'b0) begin
            n_bad++;
            $display("FAIL async_reset got state=%0d reg_write=%b required state=0 reg_write=0",
                     bus0.state, bus0.reg_write);
        end
        @(posedge clk);
        #1;
        bus0.mem_ready = 1'b1;
        sb_q.push_back(model(0, OP_R, 6'b100000, 1'b0, 1'b1, 1'b1));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_instr(OP_R, 6'b100101, 1'b0, 0, 0);

        // Random instruction stream
        for (int i = 0; i < 400; i++) begin
            sel = int'($urandom_range(0, 7));
            rfn = 6'($urandom);
            case (sel)
                0: rop = OP_LW;
                1: rop = OP_SW;
                2: begin
                    rop = OP_R;
                    case ($urandom_range(0, 5))
                        0: rfn = 6'b100000;
                        1: rfn = 6'b100010;
                        2: rfn = 6'b100100;
                        3: rfn = 6'b100101;
                        4: rfn = 6'b101010;
                        default: rfn = 6'b100111;
                    endcase
                end
                3: rop = OP_R;
                4: rop = OP_BEQ;
                5: rop = OP_ADDI;
                6: rop = OP_J;
                default: rop = 6'($urandom);
            endcase
            run_instr(rop, rfn, rbit(),
                      rbit() ? 0 : int'($urandom_range(1, 3)),
                      rbit() ? 0 : int'($urandom_range(1, 3)));
        end

        // Let the monitor drain the scoreboard
        for (int k = 0; k < 5 && sb_q.size() > 0; k++) @(posedge clk);
        if (sb_q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain got %0d pending required 0", sb_q.size());
        end

        // Handshake disabled: sw completes with mem_ready held low
        exp_st = '{0, 1, 2, 5, 0, 1};
        wr_cnt = 0;
        @(posedge clk);
        #1;
        rst1_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (bus1.mem_write === 1'b1) wr_cnt++;
            n_cmp++;
            if (bus1.state !== 4'(exp_st[k])) begin
                n_bad++;
                $display("FAIL nohs_state cycle %0d got %0d required %0d",
                         k, bus1.state, exp_st[k]);
            end
        end
        n_cmp++;
        if (wr_cnt != 1) begin
            n_bad++;
            $display("FAIL nohs_mem_write_cycles got %0d required 1", wr_cnt);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
